// File: rtl/neurex_pkg.sv
// Shared definitions for the neurex array-feed blocks: default geometry and
// the input feeder state encoding.
package neurex_pkg;

  localparam int unsigned SYS_ROW_DEF    = 16;
  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/skew_row_ctrl.sv
// One row of the skewed read sequencer: turns the shared step count into this
// bank's read enable/address and delays the enable into the row valid.
module skew_row_ctrl
  import neurex_pkg::*;
#(
  parameter int unsigned ROW        = 0,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  step_vld,
  input  logic [CNT_W-1:0]      step,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  row_valid
);

  logic [CNT_W-1:0] offs;
  logic             en_nxt;

  assign offs   = step - CNT_W'(ROW);
  assign en_nxt = step_vld && (step >= CNT_W'(ROW)) && (offs < CNT_W'(len));

  // Address is truncated so reads wrap around the top of the bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      row_valid <= 1'b0;
    end else begin
      rd_en     <= en_nxt;
      row_valid <= rd_en;
      if (en_nxt) rd_addr <= base + offs[ADDR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/input_skew_feeder.sv
// Skewed read sequencer feeding the systolic array's west edge.
// Optional INPUT_SKEW_FEEDER_ZERO_PAD_EN forces row_data to zero in skew bubbles.
module input_skew_feeder
  import neurex_pkg::*;
#(
  parameter int unsigned SYS_ROW    = SYS_ROW_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [SYS_ROW-1:0]    mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr [0:SYS_ROW-1],
  input  logic [DATA_WIDTH-1:0] mem_rd_data [0:SYS_ROW-1],
  output logic [SYS_ROW-1:0]    row_valid,
  output logic [DATA_WIDTH-1:0] row_data    [0:SYS_ROW-1]
);

  localparam int unsigned CNT_W = $clog2((2 ** ADDR_WIDTH) + SYS_ROW) + 1;

  feeder_state_t         state, state_nxt;
  logic [CNT_W-1:0]      t_q, t_nxt, step, last_step;
  logic [ADDR_WIDTH-1:0] base_q, step_base;
  logic [ADDR_WIDTH:0]   len_q, step_len;
  logic                  accept, zero_job, zero_done_q, step_vld;

  assign accept    = (state == IDLE) && start && (len != '0);
  assign zero_job  = (state == IDLE) && start && (len == '0);
  assign last_step = CNT_W'(len_q) + CNT_W'(SYS_ROW) - CNT_W'(2);

  // Row controllers register the enable for 'step', so the step presented
  // here is the one issued in the following cycle; on the accepting edge the
  // job parameters come straight from the inputs.
  always_comb begin
    state_nxt = state;
    t_nxt     = t_q;
    step      = '0;
    step_vld  = 1'b0;
    step_base = base_q;
    step_len  = len_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          t_nxt     = '0;
          step_vld  = 1'b1;
          step_base = base_addr;
          step_len  = len;
        end
      end
      RUN: begin
        if (t_q == last_step) begin
          state_nxt = DRAIN;
        end else begin
          t_nxt    = t_q + CNT_W'(1);
          step     = t_q + CNT_W'(1);
          step_vld = 1'b1;
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      t_q         <= '0;
      base_q      <= '0;
      len_q       <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      t_q         <= t_nxt;
      zero_done_q <= zero_job;
      if (accept) begin
        base_q <= base_addr;
        len_q  <= len;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DRAIN) || zero_done_q;

  for (genvar i = 0; i < SYS_ROW; i++) begin : g_row
    skew_row_ctrl #(
      .ROW       (i),
      .ADDR_WIDTH(ADDR_WIDTH),
      .CNT_W     (CNT_W)
    ) u_row (
      .clk      (clk),
      .rstn     (rstn),
      .step_vld (step_vld),
      .step     (step),
      .base     (step_base),
      .len      (step_len),
      .rd_en    (mem_rd_en[i]),
      .rd_addr  (mem_rd_addr[i]),
      .row_valid(row_valid[i])
    );

`ifdef INPUT_SKEW_FEEDER_ZERO_PAD_EN
    assign row_data[i] = row_valid[i] ? mem_rd_data[i] : '0;
`else
    assign row_data[i] = mem_rd_data[i];
`endif
  end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Randomized self-checking bench for input_skew_feeder against a cycle-indexed
// reference of the skewed read schedule and a behavioural SRAM.
module tb_input_skew_feeder;

  localparam int SR = 16;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic [SR-1:0] mem_rd_en;
  logic [AW-1:0] mem_rd_addr [0:SR-1];
  logic [DW-1:0] mem_rd_data [0:SR-1];
  logic [SR-1:0] row_valid;
  logic [DW-1:0] row_data    [0:SR-1];

  logic [DW-1:0] mem [SR][256];
  int            m_addr [SR];
  int            n_checks = 0;
  int            n_fail   = 0;

  input_skew_feeder #(
    .SYS_ROW   (SR),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .row_valid  (row_valid),
    .row_data   (row_data)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM banks with one cycle of read latency.
  always @(posedge clk) begin
    for (int i = 0; i < SR; i++)
      if (mem_rd_en[i]) mem_rd_data[i] <= mem[i][mem_rd_addr[i]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, ".row_valid"}, 32'(row_valid), 32'd0);
    for (int i = 0; i < SR; i++)
      chk($sformatf("%s.addr[%0d]", tag, i), 32'(mem_rd_addr[i]), 32'd0);
  endtask

  // Cycle 0 is the cycle in which start is held high; every later cycle is
  // compared against the schedule implied by (base, ln). A start pulse is
  // re-issued at cycle 'inj' (if positive) and must change nothing.
  task automatic run_job(input int base, input int ln, input int inj);
    int            last_c;
    int            busy_cnt;
    int            en_cnt [SR];
    logic [SR-1:0] exp_en, exp_vld;
    last_c   = ln + SR + 2;
    busy_cnt = 0;
    for (int i = 0; i < SR; i++) en_cnt[i] = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(base);
    len       = (AW+1)'(ln);
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start     = (c == inj);
        base_addr = AW'($urandom);
        len       = (AW+1)'($urandom);
      end
      @(negedge clk);
      exp_en  = '0;
      exp_vld = '0;
      for (int i = 0; i < SR; i++) begin
        exp_en[i]  = (ln > 0) && (c >= 1 + i) && (c <= i + ln);
        exp_vld[i] = (ln > 0) && (c >= 2 + i) && (c <= 1 + i + ln);
        if (exp_vld[i])
          chk($sformatf("data[%0d]@%0d", i, c), 32'(row_data[i]), 32'(mem[i][m_addr[i]]));
`ifdef INPUT_SKEW_FEEDER_ZERO_PAD_EN
        else
          chk($sformatf("pad[%0d]@%0d", i, c), 32'(row_data[i]), 32'd0);
`else
        chk($sformatf("pass[%0d]@%0d", i, c), 32'(row_data[i]), 32'(mem_rd_data[i]));
`endif
        if (exp_en[i]) m_addr[i] = (base + c - 1 - i) % 256;
        chk($sformatf("addr[%0d]@%0d", i, c), 32'(mem_rd_addr[i]), 32'(m_addr[i]));
        en_cnt[i] += int'(mem_rd_en[i]);
      end
      chk($sformatf("rd_en@%0d", c), 32'(mem_rd_en), 32'(exp_en));
      chk($sformatf("row_valid@%0d", c), 32'(row_valid), 32'(exp_vld));
      chk($sformatf("busy@%0d", c), 32'(busy),
          32'((ln > 0) && (c >= 1) && (c <= ln + SR)));
      chk($sformatf("done@%0d", c), 32'(done),
          32'((ln > 0) ? (c == ln + SR) : (c == 1)));
      busy_cnt += int'(busy);
    end
    for (int i = 0; i < SR; i++)
      chk($sformatf("en_count[%0d]", i), 32'(en_cnt[i]), 32'(ln));
    chk("busy_count", 32'(busy_cnt), 32'((ln > 0) ? ln + SR : 0));
  endtask

  task automatic reset_abort();
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'($urandom);
    len       = 9'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort.busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check_cleared("abort");
    for (int i = 0; i < SR; i++) m_addr[i] = 0;
    repeat (3) begin
      @(negedge clk);
      check_cleared("abort_hold");
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, l, inj;
    for (int i = 0; i < SR; i++) begin
      m_addr[i] = 0;
      mem_rd_data[i] = '0;
      for (int a = 0; a < 256; a++) mem[i][a] = DW'($urandom);
    end
    rstn      = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    #3;
    check_cleared("reset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    run_job(0, 4, -1);
    run_job(254, 4, -1);
    run_job($urandom_range(0, 255), 256, -1);
    run_job($urandom_range(0, 255), 0, -1);
    run_job(10, 6, 7);
    run_job(3, 5, 5 + SR);
    run_job(250, 1, -1);
    run_job(1, 255, 100);
    for (int k = 0; k < 8; k++) begin
      b   = $urandom_range(0, 255);
      l   = $urandom_range(0, 40);
      inj = ((l > 0) && ($urandom_range(0, 1) == 1)) ? $urandom_range(2, l + SR) : -1;
      run_job(b, l, inj);
    end
    reset_abort();
    run_job(100, 8, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
